// File: rtl/disp_scan_ctrl_if.sv
// Display scan bus: pattern load handshake, frame controls and the shared anode/segment pins.
// master = pattern source / pin observer, slave = scan controller.
interface disp_scan_ctrl_if;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic       load;
    logic       load_ack;
    logic [3:0] dig_en;
    logic [3:0] bright;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    modport master (
        output in0, in1, in2, in3, load, dig_en, bright,
        input  load_ack, an, sseg, frame_tick
    );

    modport slave (
        input  in0, in1, in2, in3, load, dig_en, bright,
        output load_ack, an, sseg, frame_tick
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit 7-seg scanner with frame-atomic pattern load, blanking and 16-level PWM; all pins registered (1 clk).
// No backpressure: load is held pending until the next frame boundary, acked once with a 1-cycle pulse.
module disp_scan_ctrl #(
    parameter int SUB_DIV = 256,
    parameter int BLANK   = 2
) (
    input  logic               clk,
    input  logic               reset,
    disp_scan_ctrl_if.slave    bus
);
    localparam int              CW       = $clog2(SUB_DIV);
    localparam logic [CW-1:0]   SUB_LAST = CW'(SUB_DIV - 1);
    localparam logic [4:0]      BLANK5   = 5'(BLANK);

    // scan position
    logic [CW-1:0] sub_cnt;
    logic [CW-1:0] sub_cnt_nx;
    logic [3:0]    s;
    logic [3:0]    s_nx;
    logic [1:0]    d;
    logic [1:0]    d_nx;

    // frame-latched state
    logic [3:0][7:0] shadow;
    logic [3:0]      en_r;
    logic [3:0]      bright_r;
    logic            pending;
    logic            pending_nx;

    logic       sub_wrap;
    logic       boundary;
    logic       capture;
    logic       lit;
    logic [3:0] an_nx;
    logic [7:0] sseg_nx;

    always_comb begin
        sub_wrap   = (sub_cnt == SUB_LAST);
        sub_cnt_nx = sub_wrap ? '0 : sub_cnt + 1'b1;
        s_nx       = sub_wrap ? s + 4'd1 : s;
        d_nx       = (sub_wrap && (s == 4'd15)) ? d + 2'd1 : d;
    end

    // A capture consumes the pending request, so a boundary always leaves pending clear.
    always_comb begin
        boundary   = (d == 2'd0) && (s == 4'd0) && (sub_cnt == '0);
        capture    = boundary && (pending || bus.load);
        pending_nx = boundary ? 1'b0 : (pending | bus.load);
    end

    // 5-bit compare so BLANK + bright_r past 15 simply lights to slot end.
    always_comb begin
        lit     = en_r[d]
                  && ({1'b0, s} >= BLANK5)
                  && ({1'b0, s} <  (BLANK5 + {1'b0, bright_r}));
        an_nx   = 4'hF;
        sseg_nx = 8'hFF;
        if (lit) begin
            an_nx   = ~(4'b0001 << d);
            sseg_nx = shadow[d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt <= '0;
            s       <= 4'd0;
            d       <= 2'd0;
            pending <= 1'b0;
            en_r    <= 4'h0;
            bright_r <= 4'h0;
            shadow  <= {4{8'hFF}};
        end else begin
            sub_cnt <= sub_cnt_nx;
            s       <= s_nx;
            d       <= d_nx;
            pending <= pending_nx;
            if (boundary) begin
                en_r     <= bus.dig_en;
                bright_r <= bus.bright;
            end
            if (capture) begin
                shadow <= {bus.in3, bus.in2, bus.in1, bus.in0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an         <= 4'hF;
            bus.sseg       <= 8'hFF;
            bus.load_ack   <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= an_nx;
            bus.sseg       <= sseg_nx;
            bus.load_ack   <= capture;
            bus.frame_tick <= boundary;
        end
    end

    a_one_anode: assert property (@(posedge clk) disable iff (reset)
        $onehot0(~bus.an));
    a_dark_sseg: assert property (@(posedge clk) disable iff (reset)
        (bus.an == 4'hF) |-> (bus.sseg == 8'hFF));
    a_ack_on_tick: assert property (@(posedge clk) disable iff (reset)
        bus.load_ack |-> bus.frame_tick);
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position model compared every cycle, plus directed per-frame window measurements.
module tb_disp_scan_ctrl;
    localparam int SUB_DIV = 4;
    localparam int BLANK   = 2;
    localparam int FRAME   = 64 * SUB_DIV;
    localparam int SLOT    = 16 * SUB_DIV;

    logic clk;
    logic reset;
    disp_scan_ctrl_if bus();

    disp_scan_ctrl #(.SUB_DIV(SUB_DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame is just cycles-since-reset modulo the frame length.
    int         t;
    bit         mvalid = 0;
    bit         m_pend;
    logic [3:0] m_en;
    int         m_br;
    logic [7:0] m_sh [4];
    logic [3:0] e_an;
    logic [7:0] e_sseg;
    logic       e_ack;
    logic       e_tick;

    always @(posedge clk) begin
        int pos, dd, ss;
        bit lit;
        if (reset) begin
            mvalid = 1;
            t      = 0;
            m_pend = 0;
            m_en   = 4'h0;
            m_br   = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 8'hFF;
            e_an   = 4'hF;
            e_sseg = 8'hFF;
            e_ack  = 0;
            e_tick = 0;
        end else begin
            pos = t % FRAME;
            dd  = pos / SLOT;
            ss  = (pos % SLOT) / SUB_DIV;
            lit = m_en[dd] && (ss >= BLANK) && (ss < BLANK + m_br);
            e_an   = lit ? ~(4'(1) << dd) : 4'hF;
            e_sseg = lit ? m_sh[dd] : 8'hFF;
            e_tick = (pos == 0);
            e_ack  = 0;
            if (pos == 0) begin
                m_en = bus.dig_en;
                m_br = int'(bus.bright);
                if (m_pend || bus.load) begin
                    m_sh[0] = bus.in0; m_sh[1] = bus.in1;
                    m_sh[2] = bus.in2; m_sh[3] = bus.in3;
                    m_pend = 0;
                    e_ack  = 1;
                end
            end else if (bus.load) begin
                m_pend = 1;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_an",         32'(bus.an),         32'(e_an));
            chk("model_sseg",       32'(bus.sseg),       32'(e_sseg));
            chk("model_load_ack",   32'(bus.load_ack),   32'(e_ack));
            chk("model_frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        end
    end

    task automatic wait_tick();
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) return;
        end
        chk("wait_tick_timeout", 32'd0, 32'd1);
    endtask

    // Called at the negedge where frame_tick is high; walks the frame and ends on the next tick.
    task automatic measure(input string tag, input logic [31:0] lens, input logic [31:0] pats);
        int cnt [4];
        int first [4];
        int last [4];
        logic [7:0] pat [4];
        logic [3:0] one;
        int nack = 0;
        int ntick = 0;
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0; first[k] = -1; last[k] = -1; pat[k] = 8'h00;
        end
        for (int off = 1; off < FRAME; off++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                one = 4'b0001 << k;
                if (bus.an === ~one) begin
                    if (first[k] < 0) begin
                        first[k] = off;
                        pat[k]   = bus.sseg;
                    end
                    last[k] = off;
                    cnt[k]++;
                end
            end
            if (bus.load_ack === 1'b1) nack++;
            if (bus.frame_tick === 1'b1) ntick++;
        end
        @(negedge clk);
        if (bus.load_ack === 1'b1) nack++;
        chk({tag, "_tick_period"}, 32'(bus.frame_tick), 32'd1);
        chk({tag, "_no_extra_tick"}, 32'(ntick), 32'd0);
        chk({tag, "_no_ack"}, 32'(nack), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_len%0d", tag, k), 32'(cnt[k]), 32'(lens[8*k +: 8]));
            if (lens[8*k +: 8] != 8'd0) begin
                chk($sformatf("%s_start%0d", tag, k), 32'(first[k]), 32'(SLOT * k + BLANK * SUB_DIV));
                chk($sformatf("%s_contig%0d", tag, k), 32'(last[k] - first[k] + 1), 32'(cnt[k]));
                chk($sformatf("%s_pat%0d", tag, k), 32'(pat[k]), 32'(pats[8*k +: 8]));
            end
        end
    endtask

    initial begin
        int nack;
        int bad;
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.in0    = 8'hC0;
        bus.in1    = 8'hF9;
        bus.in2    = 8'hA4;
        bus.in3    = 8'hB0;
        bus.dig_en = 4'hF;
        bus.bright = 4'd15;

        repeat (3) @(negedge clk);
        chk("rst_an",   32'(bus.an),         32'hF);
        chk("rst_sseg", 32'(bus.sseg),       32'hFF);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_tick", 32'(bus.frame_tick), 32'd1);
        @(negedge clk);
        chk("rel_tick_low", 32'(bus.frame_tick), 32'd0);

        // Mid-frame reset for 3 cycles.
        repeat (100) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_an",   32'(bus.an),         32'hF);
            chk("mid_rst_sseg", 32'(bus.sseg),       32'hFF);
            chk("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
            chk("mid_rst_ack",  32'(bus.load_ack),   32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rel_tick", 32'(bus.frame_tick), 32'd1);

        // Full display.
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_tick();
        chk("full_ack", 32'(bus.load_ack), 32'd1);
        measure("full", {8'd56, 8'd56, 8'd56, 8'd56}, 32'hB0A4F9C0);

        // Brightness: change just after a boundary, effective one frame later.
        bus.bright = 4'd4;
        measure("br_hold", {8'd56, 8'd56, 8'd56, 8'd56}, 32'hB0A4F9C0);
        measure("br4", {8'd16, 8'd16, 8'd16, 8'd16}, 32'hB0A4F9C0);

        // Enables.
        bus.dig_en = 4'b0101;
        bus.bright = 4'd15;
        measure("en_hold", {8'd16, 8'd16, 8'd16, 8'd16}, 32'hB0A4F9C0);
        bus.dig_en = 4'hF;
        measure("en0101", {8'd0, 8'd56, 8'd0, 8'd56}, 32'hB0A4F9C0);

        // Handshake: two loads in one frame give one ack with in0 as seen at the boundary.
        nack = 0;
        bad  = 0;
        for (int off = 1; off < FRAME; off++) begin
            @(negedge clk);
            if (bus.load_ack === 1'b1) nack++;
            if (bus.an === 4'b1110 && bus.sseg !== 8'hC0) bad++;
            if (off == 30) begin bus.in0 = 8'h99; bus.load = 1'b1; end
            if (off == 31) bus.load = 1'b0;
            if (off == 40) begin bus.in0 = 8'h92; bus.load = 1'b1; end
            if (off == 41) bus.load = 1'b0;
        end
        @(negedge clk);
        chk("hs_tick", 32'(bus.frame_tick), 32'd1);
        chk("hs_ack", 32'(bus.load_ack), 32'd1);
        chk("hs_no_early_ack", 32'(nack), 32'd0);
        chk("hs_no_early_change", 32'(bad), 32'd0);
        measure("hs_show", {8'd56, 8'd56, 8'd56, 8'd56}, 32'hB0A4F992);

        // Dark.
        bus.bright = 4'd0;
        measure("dark_hold", {8'd56, 8'd56, 8'd56, 8'd56}, 32'hB0A4F992);
        measure("dark", {8'd0, 8'd0, 8'd0, 8'd0}, 32'hB0A4F992);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
